// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: sync, blanking, coordinates and frame/line pulses.
// Outputs are registered from next-state counters; en=0 holds position and suppresses pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          isDispRGB,
  output logic          dispPulse,
  output logic          lineStart,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);

  // Region bounds kept 32 bits wide so a zero back porch cannot overflow CW.
  localparam logic [31:0] H_ACT_END  = 32'(H_ACTIVE);
  localparam logic [31:0] H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END  = 32'(V_ACTIVE);
  localparam logic [31:0] V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic [31:0]   x_ext;
  logic [31:0]   y_ext;
  logic          x_wrap;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          de_nxt;

  always_comb begin
    x_wrap = (x == X_LAST);
    x_nxt  = x_wrap ? '0 : x + CW'(1);
    y_nxt  = y;
    if (x_wrap) begin
      y_nxt = (y == Y_LAST) ? '0 : y + CW'(1);
    end
    x_ext  = 32'(x_nxt);
    y_ext  = 32'(y_nxt);
    hs_nxt = (x_ext >= H_SYNC_BEG && x_ext < H_SYNC_END) ? HS_ACT : ~HS_ACT;
    vs_nxt = (y_ext >= V_SYNC_BEG && y_ext < V_SYNC_END) ? VS_ACT : ~VS_ACT;
    de_nxt = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
  end

  // Reset parks at the last pixel so the first enabled edge lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= X_LAST;
      y         <= Y_LAST;
      hsync     <= ~HS_ACT;
      vsync     <= ~VS_ACT;
      isDispRGB <= 1'b0;
      dispPulse <= 1'b0;
      lineStart <= 1'b0;
    end else if (en) begin
      x         <= x_nxt;
      y         <= y_nxt;
      hsync     <= hs_nxt;
      vsync     <= vs_nxt;
      isDispRGB <= de_nxt;
      lineStart <= (x_nxt == '0);
      dispPulse <= (x_nxt == '0) && (y_nxt == '0);
    end else begin
      lineStart <= 1'b0;
      dispPulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, reduced-height and tiny active-high modes.
module tb_vga_timing_gen;

  localparam int M_VA = 8, M_VF = 2, M_VS = 2, M_VB = 3;
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 1;
  localparam int S_VA = 4, S_VF = 1, S_VS = 1, S_VB = 1;

  logic clk = 1'b0;
  logic rst_a, rst_m, rst_s;
  logic en_a = 1'b0, en_m = 1'b0, en_s = 1'b0;

  logic       hsa, vsa, dea, dpa, lsa;
  logic [9:0] xa, ya;
  logic       hsm, vsm, dem, dpm, lsm;
  logic [9:0] xm, ym;
  logic       hss, vss, des, dps, lss;
  logic [3:0] xs, ys;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .hsync(hsa), .vsync(vsa),
    .isDispRGB(dea), .dispPulse(dpa), .lineStart(lsa), .x(xa), .y(ya)
  );

  vga_timing_gen #(
    .V_ACTIVE(M_VA), .V_FP(M_VF), .V_SYNC(M_VS), .V_BP(M_VB)
  ) u_m (
    .clk(clk), .rst(rst_m), .en(en_m), .hsync(hsm), .vsync(vsm),
    .isDispRGB(dem), .dispPulse(dpm), .lineStart(lsm), .x(xm), .y(ym)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1), .VS_POL(1), .CW(4)
  ) u_s (
    .clk(clk), .rst(rst_s), .en(en_s), .hsync(hss), .vsync(vss),
    .isDispRGB(des), .dispPulse(dps), .lineStart(lss), .x(xs), .y(ys)
  );

  always #5 clk = ~clk;

  int ha[3]  = '{640, 640, S_HA};
  int hf[3]  = '{16, 16, S_HF};
  int hsw[3] = '{96, 96, S_HS};
  int hb[3]  = '{48, 48, S_HB};
  int va[3]  = '{480, M_VA, S_VA};
  int vf[3]  = '{10, M_VF, S_VF};
  int vsw[3] = '{2, M_VS, S_VS};
  int vb[3]  = '{33, M_VB, S_VB};
  int pol[3] = '{0, 0, 1};
  int cw[3]  = '{10, 10, 4};

  function automatic int ht(int d);
    return ha[d] + hf[d] + hsw[d] + hb[d];
  endfunction

  function automatic int vt(int d);
    return va[d] + vf[d] + vsw[d] + vb[d];
  endfunction

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs, vs, de, dp, ls;
  } obs_t;

  typedef struct {
    int   d;
    obs_t o;
    int   eidx;
  } ent_t;

  ent_t q[$];
  int mx[3], my[3], edges[3];
  int n_chk = 0, n_pass = 0;

  int hs_cnt[3], vs_cnt[3], de_bad[3], ls_int[3], dp_int[3], stretch[3];
  int hs_min[3] = '{9999, 9999, 9999};
  int hs_max[3] = '{-1, -1, -1};
  int vs_min[3] = '{9999, 9999, 9999};
  int vs_max[3] = '{-1, -1, -1};
  int de_lo_min[3] = '{9999, 9999, 9999};
  int last_ls[3] = '{-1, -1, -1};
  int last_dp[3] = '{-1, -1, -1};
  logic prev_ls[3], prev_dp[3];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  function automatic obs_t cur(int d);
    case (d)
      0:       return {xa, ya, hsa, vsa, dea, dpa, lsa};
      1:       return {xm, ym, hsm, vsm, dem, dpm, lsm};
      default: return {6'd0, xs, 6'd0, ys, hss, vss, des, dps, lss};
    endcase
  endfunction

  task automatic model_reset(int d);
    mx[d] = ht(d) - 1;
    my[d] = vt(d) - 1;
  endtask

  task automatic push(int d, logic dp, logic ls);
    ent_t e;
    logic p;
    int hsb, vsb;
    p    = (pol[d] != 0);
    hsb  = ha[d] + hf[d];
    vsb  = va[d] + vf[d];
    e.d  = d;
    e.eidx = edges[d];
    e.o.x  = 10'(mx[d]);
    e.o.y  = 10'(my[d]);
    e.o.hs = (mx[d] >= hsb && mx[d] < hsb + hsw[d]) ? p : !p;
    e.o.vs = (my[d] >= vsb && my[d] < vsb + vsw[d]) ? p : !p;
    e.o.de = (mx[d] < ha[d]) && (my[d] < va[d]);
    e.o.dp = dp;
    e.o.ls = ls;
    q.push_back(e);
  endtask

  // One clock for DUT d; expected response is queued for the monitor.
  task automatic step(int d, logic e);
    en_a = (d == 0) && e;
    en_m = (d == 1) && e;
    en_s = (d == 2) && e;
    @(posedge clk);
    #1;
    if (e) begin
      edges[d]++;
      if (mx[d] == ht(d) - 1) begin
        mx[d] = 0;
        my[d] = (my[d] == vt(d) - 1) ? 0 : my[d] + 1;
      end else begin
        mx[d]++;
      end
    end
    push(d, e && mx[d] == 0 && my[d] == 0, e && mx[d] == 0);
  endtask

  ent_t me;
  obs_t mg;
  int   md, gx, gy;

  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        me = q.pop_front();
        md = me.d;
        mg = cur(md);
        chk($sformatf("sb_dut%0d_edge%0d", md, me.eidx), 64'(mg), 64'(me.o));
        gx = int'(mg.x);
        gy = int'(mg.y);
        if (mg.hs == (pol[md] != 0)) begin
          hs_cnt[md]++;
          if (gx < hs_min[md]) hs_min[md] = gx;
          if (gx > hs_max[md]) hs_max[md] = gx;
        end
        if (mg.vs == (pol[md] != 0)) begin
          vs_cnt[md]++;
          if (gy < vs_min[md]) vs_min[md] = gy;
          if (gy > vs_max[md]) vs_max[md] = gy;
        end
        if (mg.de && gy >= va[md]) de_bad[md]++;
        if (!mg.de && gy < va[md] && gx < de_lo_min[md]) de_lo_min[md] = gx;
        if (mg.ls) begin
          if (prev_ls[md]) stretch[md]++;
          if (last_ls[md] >= 0) ls_int[md] = me.eidx - last_ls[md];
          last_ls[md] = me.eidx;
        end
        if (mg.dp) begin
          if (prev_dp[md]) stretch[md]++;
          if (last_dp[md] >= 0) dp_int[md] = me.eidx - last_dp[md];
          last_dp[md] = me.eidx;
        end
        prev_ls[md] = mg.ls;
        prev_dp[md] = mg.dp;
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      if (ht(d) - 1 >= (1 << cw[d]) || vt(d) - 1 >= (1 << cw[d])) begin
        $display("FAIL cw_bound: mode %0d totals %0d/%0d exceed width %0d",
                 d, ht(d), vt(d), cw[d]);
        $fatal(1, "counter width too small");
      end
    end

    rst_a = 1'b1; rst_m = 1'b1; rst_s = 1'b1;
    for (int d = 0; d < 3; d++) model_reset(d);
    #1;
    for (int d = 0; d < 3; d++) push(d, 1'b0, 1'b0);
    chk("rst_a", 64'({xa, ya, hsa, vsa, dea, dpa, lsa}), 64'({10'd799, 10'd524, 5'b11000}));
    chk("rst_s", 64'({xs, ys, hss, vss, des, dps, lss}), 64'({4'd13, 4'd6, 5'b00000}));
    @(negedge clk);
    #1;
    rst_a = 1'b0; rst_m = 1'b0; rst_s = 1'b0;

    // Default mode: first edge, one full line, then 1,0,0 gated enable.
    step(0, 1'b1);
    chk("a_first", 64'({xa, ya, dea, dpa, lsa}), 64'({10'd0, 10'd0, 3'b111}));
    repeat (799) step(0, 1'b1);
    @(negedge clk);
    #1;
    chk("a_hs_cnt", 64'(hs_cnt[0]), 64'd96);
    chk("a_hs_min", 64'(hs_min[0]), 64'd656);
    chk("a_hs_max", 64'(hs_max[0]), 64'd751);
    chk("a_de_lo",  64'(de_lo_min[0]), 64'd640);
    step(0, 1'b1);
    chk("a_line1", 64'({xa, ya, lsa}), 64'({10'd0, 10'd1, 1'b1}));
    @(negedge clk);
    #1;
    chk("a_ls_int", 64'(ls_int[0]), 64'd800);
    for (int i = 0; i < 2400; i++) step(0, (i % 3) == 0);
    @(negedge clk);
    #1;
    chk("a_gated_pos", 64'({xa, ya}), 64'({10'd0, 10'd2}));
    chk("a_gated_ls_int", 64'(ls_int[0]), 64'd800);
    chk("a_stretch", 64'(stretch[0]), 64'd0);

    // Reduced-height mode: full frame, then async reset mid-frame.
    step(1, 1'b1);
    chk("m_first", 64'({xm, ym, dpm}), 64'({10'd0, 10'd0, 1'b1}));
    repeat (11999) step(1, 1'b1);
    @(negedge clk);
    #1;
    chk("m_vs_cnt", 64'(vs_cnt[1]), 64'd1600);
    chk("m_vs_min", 64'(vs_min[1]), 64'd10);
    chk("m_vs_max", 64'(vs_max[1]), 64'd11);
    chk("m_de_bad", 64'(de_bad[1]), 64'd0);
    step(1, 1'b1);
    @(negedge clk);
    #1;
    chk("m_dp_int", 64'(dp_int[1]), 64'd12000);
    repeat (4300) step(1, 1'b1);
    chk("m_pos", 64'({xm, ym}), 64'({10'd300, 10'd5}));
    en_m = 1'b0;
    @(posedge clk);
    #3;
    rst_m = 1'b1;
    model_reset(1);
    #1;
    push(1, 1'b0, 1'b0);
    chk("m_rst_async", 64'({xm, ym, hsm, vsm, dem, dpm, lsm}), 64'({10'd799, 10'd14, 5'b11000}));
    @(negedge clk);
    #1;
    rst_m = 1'b0;
    step(1, 1'b1);
    chk("m_restart", 64'({xm, ym, dpm, lsm}), 64'({10'd0, 10'd0, 2'b11}));

    // Tiny mode, active-high syncs.
    step(2, 1'b1);
    chk("s_first", 64'({xs, ys, dps}), 64'({4'd0, 4'd0, 1'b1}));
    repeat (97) step(2, 1'b1);
    @(negedge clk);
    #1;
    chk("s_hs_cnt", 64'(hs_cnt[2]), 64'd21);
    chk("s_hs_min", 64'(hs_min[2]), 64'd10);
    chk("s_hs_max", 64'(hs_max[2]), 64'd12);
    chk("s_vs_cnt", 64'(vs_cnt[2]), 64'd14);
    chk("s_vs_min", 64'(vs_min[2]), 64'd5);
    chk("s_vs_max", 64'(vs_max[2]), 64'd5);
    chk("s_de_lo",  64'(de_lo_min[2]), 64'd8);
    step(2, 1'b1);
    en_s = 1'b0;
    @(negedge clk);
    #1;
    chk("s_dp_int", 64'(dp_int[2]), 64'd98);

    @(negedge clk);
    #1;
    chk("q_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
